key_debounce_array: RTL and testbench
=====================================

// Module: key_debounce_array
// PURPOSE
//  N-channel push-button conditioner running on the board clock. Does not use a derived debounce clock.
//  Per key: 2-FF synchroniser, sampled debounce with a stability count, and an event FSM.
//  Emits a clean level plus 1-clk press/release/long-press pulses to gomoku_main and future game logic.
//  Also exports its internal sample tick for reuse by other slow-rate logic.
// PARAMETERS
//  N_KEYS         8        number of independent key channels
//  CLK_FREQ       1000000  clk frequency, Hz
//  SAMPLE_HZ      100      debounce sample rate; DIV = CLK_FREQ/SAMPLE_HZ, must be >= 2
//  STABLE_SAMPLES 4        consecutive equal samples needed to accept a level change (>= 1)
//  LONG_SAMPLES   100      samples held (after accept) before key_long fires
//  REPEAT_SAMPLES 20       auto-repeat period in samples (only used with the repeat macro)
//  INVERT_MASK    8'h00    bit i = 1: key i is active-low at the pin
// PORTS
//  clk          in   1       board clock
//  rst_n        in   1       asynchronous, active-low reset
//  key_in       in   N_KEYS  raw pin levels
//  sample_tick  out  1       1-clk pulse every DIV clocks
//  key_level    out  N_KEYS  debounced pressed level (1 = pressed)
//  key_press    out  N_KEYS  1-clk pulse on accepted press (and on each repeat, see CONFIGURATION)
//  key_release  out  N_KEYS  1-clk pulse on accepted release
//  key_long     out  N_KEYS  1-clk pulse when hold reaches LONG_SAMPLES
// BEHAVIOUR
//  - Reset (async assert, sync release through normal flops):
//    - all outputs 0, divider 0, sync flops 0, every FSM in IDLE.
//  - Polarity: p = sync(key_in[i]) ^ INVERT_MASK[i].
//  - Divider: counts 0..DIV-1, $clog2(DIV) bits; sample_tick=1 in the cycle count==DIV-1, then wraps to 0.
//  - All FSM/counter updates happen only on sample_tick cycles.
//    - Pulses are registered and asserted in the clk cycle after the deciding tick.
//    - Each pulse lasts exactly 1 clk.
//  - Per-channel FSM:
//    - IDLE: p=1 -> PRESS_WAIT, cnt=1.
//    - PRESS_WAIT:
//      - p=0 -> IDLE (glitch dropped, no pulse).
//      - p=1 and cnt+1==STABLE_SAMPLES -> HELD, key_level=1, key_press pulse, hold=0.
//      - otherwise cnt++.
//      - With STABLE_SAMPLES=1, the same tick goes IDLE->HELD directly.
//    - HELD:
//      - p=0 -> RELEASE_WAIT, cnt=1.
//      - p=1 -> hold++; hold reaching LONG_SAMPLES -> LONG_HELD, key_long pulse.
//    - LONG_HELD: p=0 -> RELEASE_WAIT, cnt=1; otherwise stay, no further key_long.
//    - RELEASE_WAIT:
//      - p=1 -> back to the state it came from (HELD or LONG_HELD; keep 1 bit of origin); hold is not cleared.
//      - p=0 and cnt+1==STABLE_SAMPLES -> IDLE, key_level=0, key_release pulse.
//  - Widths and saturation:
//    - Stability counter: $clog2(STABLE_SAMPLES+1) bits.
//    - Hold counter: $clog2(LONG_SAMPLES+1) bits; saturates, never wraps.
//  - Boundaries:
//    - Key already pressed when rst_n releases: reported as a fresh press after STABLE_SAMPLES ticks.
//    - Channels are independent: simultaneous events on different keys all pulse in the same cycle.
//    - press and release never pulse in the same cycle on one key.
//    - Reset mid-hold: all outputs drop to 0 at once; no release pulse is produced.
// CONFIGURATION
//  - Macro KEY_DEBOUNCE_AUTOREPEAT_EN defined:
//    - In LONG_HELD, a repeat counter runs; key_press pulses every REPEAT_SAMPLES ticks while held.
//    - The first repeat is REPEAT_SAMPLES ticks after key_long.
//    - The repeat counter clears on leaving LONG_HELD.
//  - Macro undefined: no repeat counter is built; key_press fires once per accepted press.
// STRUCTURE
//  - Shared package/header key_pkg:
//    - FSM state encoding: IDLE, PRESS_WAIT, HELD, LONG_HELD, RELEASE_WAIT.
//    - A width helper for the counters.
//  - Sub-module key_debounce_chan: sync flops, FSM and counters for one key.
//    - Instantiated N_KEYS times by a generate loop.
//    - Divider and sample_tick live in the top-level module and are shared.
// TESTING (bench: CLK_FREQ=1000, SAMPLE_HZ=100 -> DIV=10; STABLE=4, LONG=10, REPEAT=3)
//  1. Reset, then idle: sample_tick every 10 clk; all key_* outputs 0.
//  2. Glitch: key_in[0]=1 for 25 clk, then 0 -> no key_press, key_level[0] stays 0.
//  3. Clean press/release: key_in[1] held 1 for 300 clk, then 0.
//     - Exactly one key_press[1], 4 ticks after the edge (+sync/tick alignment).
//     - key_long[1] 10 ticks after the press.
//     - key_release[1] 4 ticks after the falling edge.
//  4. Bounce: toggle key_in[2] each 10 clk for 60 clk, then hold 1.
//     - One key_press, counted from the last rising edge.
//  5. INVERT_MASK[3]=1, pin driven 0: key_level[3]=1 after 4 ticks.
//     - Assert rst_n=0 mid-hold: all outputs 0 the same clk; no release pulse.
//  6. With KEY_DEBOUNCE_AUTOREPEAT_EN: hold key 0 for 30 ticks.
//     - key_press at accept, then at long+3, +6, +9 ... ticks.
//     - Without the macro: single key_press only.

Source files
------------

// File: rtl/key_debounce_array_pkg.sv
// Shared types for the key debounce array: per-channel FSM state encoding
// and the counter width helper.
package key_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      LONG_HELD    = 3'd3,
      RELEASE_WAIT = 3'd4
   } key_state_e;

   // Bits needed to hold values 0..max_val inclusive (never less than 1).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// Key bundle between the pins/game logic and the debounce array.
// Pulses are 1-clk wide and only follow a sample_tick cycle; there is no backpressure.
interface key_debounce_array_if #(
   parameter int N_KEYS = 8
);
   logic [N_KEYS-1:0]   key_in;
   logic                sample_tick;
   logic [N_KEYS-1:0]   key_level;
   logic [N_KEYS-1:0]   key_press;
   logic [N_KEYS-1:0]   key_release;
   logic [N_KEYS-1:0]   key_long;
   logic [3*N_KEYS-1:0] dbg_state;

   modport master (
      output key_in,
      input  sample_tick, key_level, key_press, key_release, key_long, dbg_state
   );

   modport slave (
      input  key_in,
      output sample_tick, key_level, key_press, key_release, key_long, dbg_state
   );
endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, sampled stability count and event FSM.
// Optional auto-repeat in LONG_HELD when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module key_debounce_chan
   import key_pkg::*;
#(
   parameter int   STABLE_SAMPLES = 4,
   parameter int   LONG_SAMPLES   = 100,
   parameter int   REPEAT_SAMPLES = 20,
   parameter logic INVERT         = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_i,
   input  logic       key_i,
   output logic       level_o,
   output logic       press_o,
   output logic       release_o,
   output logic       long_o,
   output key_state_e state_o
);

   localparam int CNT_W  = cnt_width(STABLE_SAMPLES);
   localparam int HOLD_W = cnt_width(LONG_SAMPLES);
   localparam logic [CNT_W-1:0]  STABLE_C = CNT_W'(STABLE_SAMPLES);
   localparam logic [HOLD_W-1:0] LONG_C   = HOLD_W'(LONG_SAMPLES);

   if (STABLE_SAMPLES < 1 || REPEAT_SAMPLES < 1) begin : g_param_check
      $error("key_debounce_chan: STABLE_SAMPLES and REPEAT_SAMPLES must be >= 1");
   end

   logic              sync1_q, sync2_q;
   logic              p;
   key_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              from_long_q;
   logic              level_q, press_q, release_q, long_q;

   assign p      = sync2_q ^ INVERT;
   assign cnt_d  = cnt_q + CNT_W'(1);
   assign hold_d = (hold_q == LONG_C) ? hold_q : hold_q + HOLD_W'(1);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
   localparam int REP_W = cnt_width(REPEAT_SAMPLES);
   localparam logic [REP_W-1:0] REPEAT_C = REP_W'(REPEAT_SAMPLES);
   logic [REP_W-1:0] rep_q, rep_d;
   assign rep_d = rep_q + REP_W'(1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         from_long_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         sync1_q   <= key_i;
         sync2_q   <= sync1_q;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         if (tick_i) begin
            case (state_q)
               IDLE: begin
                  if (p) begin
                     if (STABLE_SAMPLES <= 1) begin
                        state_q <= HELD;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        hold_q  <= '0;
                     end else begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_W'(1);
                     end
                  end
               end
               PRESS_WAIT: begin
                  if (!p) begin
                     state_q <= IDLE;
                  end else if (cnt_d == STABLE_C) begin
                     state_q <= HELD;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                     hold_q  <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               HELD, LONG_HELD: begin
                  if (!p) begin
                     from_long_q <= (state_q == LONG_HELD);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                     rep_q       <= '0;
`endif
                     // A single-sample filter releases on the very first low sample.
                     if (STABLE_SAMPLES <= 1) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        hold_q    <= '0;
                     end else begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_W'(1);
                     end
                  end else if (state_q == HELD) begin
                     hold_q <= hold_d;
                     if (hold_d == LONG_C) begin
                        state_q <= LONG_HELD;
                        long_q  <= 1'b1;
                     end
                  end else begin
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                     if (rep_d == REPEAT_C) begin
                        press_q <= 1'b1;
                        rep_q   <= '0;
                     end else begin
                        rep_q <= rep_d;
                     end
`endif
                  end
               end
               RELEASE_WAIT: begin
                  if (p) begin
                     state_q <= from_long_q ? LONG_HELD : HELD;
                  end else if (cnt_d == STABLE_C) begin
                     state_q   <= IDLE;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                     hold_q    <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign state_o   = state_q;

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button conditioner with a shared sample divider.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to build the auto-repeat counters.
module key_debounce_array
   import key_pkg::*;
#(
   parameter int              N_KEYS         = 8,
   parameter int              CLK_FREQ       = 1000000,
   parameter int              SAMPLE_HZ      = 100,
   parameter int              STABLE_SAMPLES = 4,
   parameter int              LONG_SAMPLES   = 100,
   parameter int              REPEAT_SAMPLES = 20,
   parameter logic [N_KEYS-1:0] INVERT_MASK  = '0
) (
   input logic                   clk,
   input logic                   rst_n,
   key_debounce_array_if.slave   bus
);

   localparam int DIV   = CLK_FREQ / SAMPLE_HZ;
   localparam int DIV_W = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   if (DIV < 2) begin : g_param_check
      $error("key_debounce_array: CLK_FREQ/SAMPLE_HZ must be >= 2");
   end

   logic [DIV_W-1:0]    div_q;
   logic                tick;
   logic [N_KEYS-1:0]   level_w, press_w, release_w, long_w;
   logic [3*N_KEYS-1:0] dbg_w;

   assign tick = (div_q == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + DIV_W'(1);
      end
   end

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_state_e st_w;

      key_debounce_chan #(
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .LONG_SAMPLES   (LONG_SAMPLES),
         .REPEAT_SAMPLES (REPEAT_SAMPLES),
         .INVERT         (INVERT_MASK[g])
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick_i    (tick),
         .key_i     (bus.key_in[g]),
         .level_o   (level_w[g]),
         .press_o   (press_w[g]),
         .release_o (release_w[g]),
         .long_o    (long_w[g]),
         .state_o   (st_w)
      );

      assign dbg_w[g*3 +: 3] = st_w;
   end

   assign bus.sample_tick = tick;
   assign bus.key_level   = level_w;
   assign bus.key_press   = press_w;
   assign bus.key_release = release_w;
   assign bus.key_long    = long_w;
   assign bus.dbg_state   = dbg_w;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: directed scenarios plus random key activity,
// checked cycle by cycle against a sample-sequence reference model.
module tb_key_debounce_array;

   localparam int N      = 8;
   localparam int CLKF   = 1000;
   localparam int SHZ    = 100;
   localparam int DIV    = CLKF / SHZ;
   localparam int STABLE = 4;
   localparam int LONG   = 10;
   localparam int REPEAT = 3;
   localparam logic [N-1:0] INV = 8'h08;
   localparam int RW     = 4 * N + 1;

   logic clk;
   logic rst_n;

   key_debounce_array_if #(.N_KEYS(N)) bus ();

   key_debounce_array #(
      .N_KEYS         (N),
      .CLK_FREQ       (CLKF),
      .SAMPLE_HZ      (SHZ),
      .STABLE_SAMPLES (STABLE),
      .LONG_SAMPLES   (LONG),
      .REPEAT_SAMPLES (REPEAT),
      .INVERT_MASK    (INV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // record layout: {sample_tick, level, long, release, press}
   logic [RW-1:0] exp_q[$];

   int act_press[N], act_rel[N], act_long[N];
   int exp_press[N], exp_rel[N], exp_long[N];

   // reference model: works on the stream of synchronised samples per key
   int ecnt;
   int run[N], hold[N], rep[N];
   bit lvl[N], long_done[N], prev[N], h1[N], h2[N];

   always @(posedge clk) begin : model
      logic [N-1:0] e_press, e_rel, e_long, e_lvl;
      bit e_tick;
      bit p;
      if (!rst_n) begin
         ecnt = 0;
         for (int k = 0; k < N; k++) begin
            run[k] = 0; hold[k] = 0; rep[k] = 0;
            lvl[k] = 0; long_done[k] = 0; prev[k] = 0; h1[k] = 0; h2[k] = 0;
         end
      end else begin
         ecnt++;
         e_press = '0; e_rel = '0; e_long = '0;
         if (ecnt % DIV == 0) begin
            for (int k = 0; k < N; k++) begin
               p = h2[k] ^ INV[k];
               if (p != lvl[k]) run[k]++;
               else run[k] = 0;
               if (run[k] == STABLE) begin
                  lvl[k] = p;
                  run[k] = 0;
                  if (p) begin
                     e_press[k] = 1'b1; exp_press[k]++;
                     hold[k] = 0; long_done[k] = 0; rep[k] = 0;
                  end else begin
                     e_rel[k] = 1'b1; exp_rel[k]++;
                  end
               end else if (lvl[k]) begin
                  if (p && prev[k]) begin
                     if (!long_done[k]) begin
                        hold[k]++;
                        if (hold[k] == LONG) begin
                           e_long[k] = 1'b1; exp_long[k]++;
                           long_done[k] = 1; rep[k] = 0;
                        end
                     end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                     else begin
                        rep[k]++;
                        if (rep[k] == REPEAT) begin
                           e_press[k] = 1'b1; exp_press[k]++;
                           rep[k] = 0;
                        end
                     end
`endif
                  end else if (!p) begin
                     rep[k] = 0;
                  end
               end
               prev[k] = p;
            end
         end
         for (int k = 0; k < N; k++) e_lvl[k] = lvl[k];
         e_tick = (ecnt % DIV == DIV - 1);
         exp_q.push_back({e_tick, e_lvl, e_long, e_rel, e_press});
         for (int k = 0; k < N; k++) begin
            h2[k] = h1[k];
            h1[k] = bus.key_in[k];
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin : monitor
      logic [RW-1:0] act, exp_v;
      act = {bus.sample_tick, bus.key_level, bus.key_long, bus.key_release, bus.key_press};
      if (!rst_n) begin
         exp_q.delete();
         checks++;
         if (act != '0) begin
            failures++;
            $display("FAIL reset_outputs t=%0t got=%h want=0", $time, act);
         end
      end else if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (act != exp_v) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got{tick,lvl,long,rel,press}=%h want=%h",
                     $time, act, exp_v);
         end
         for (int k = 0; k < N; k++) begin
            act_press[k] += int'(bus.key_press[k]);
            act_rel[k]   += int'(bus.key_release[k]);
            act_long[k]  += int'(bus.key_long[k]);
         end
      end
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   int snap_p, snap_r, snap_l, snap_ep;
   int remain[N];

   initial begin
      for (int k = 0; k < N; k++) begin
         act_press[k] = 0; act_rel[k] = 0; act_long[k] = 0;
         exp_press[k] = 0; exp_rel[k] = 0; exp_long[k] = 0;
      end
      rst_n      = 1'b0;
      bus.key_in = INV;
      step(3);
      rst_n = 1'b1;

      // idle: tick cadence and quiet outputs are checked by the monitor
      step(40);

      // short glitch on key 0
      snap_p = act_press[0];
      bus.key_in[0] = 1'b1;
      step(25);
      bus.key_in[0] = 1'b0;
      step(80);
      check_int("glitch_press0", act_press[0] - snap_p, 0);
      check_int("glitch_level0", int'(bus.key_level[0]), 0);

      // clean press / long / release on key 1
      snap_p = act_press[1]; snap_r = act_rel[1]; snap_l = act_long[1];
      bus.key_in[1] = 1'b1;
      step(300);
      check_int("hold_level1", int'(bus.key_level[1]), 1);
      bus.key_in[1] = 1'b0;
      step(100);
      check_int("clean_press1", act_press[1] - snap_p, 1);
      check_int("clean_long1", act_long[1] - snap_l, 1);
      check_int("clean_release1", act_rel[1] - snap_r, 1);

      // bounce on key 2, then a steady hold
      snap_p = act_press[2];
      for (int i = 0; i < 6; i++) begin
         bus.key_in[2] = ~bus.key_in[2];
         step(10);
      end
      bus.key_in[2] = 1'b1;
      step(100);
      check_int("bounce_press2", act_press[2] - snap_p, 1);
      bus.key_in[2] = 1'b0;
      step(80);

      // inverted key 3, reset mid-hold
      bus.key_in[3] = 1'b0;
      step(60);
      check_int("invert_level3", int'(bus.key_level[3]), 1);
      step(50);
      snap_r = act_rel[3];
      rst_n = 1'b0;
      #1;
      check_int("async_reset_outputs",
                int'({bus.sample_tick, bus.key_level, bus.key_long, bus.key_release, bus.key_press} != '0), 0);
      step(3);
      rst_n = 1'b1;
      step(80);
      check_int("reset_no_release3", act_rel[3] - snap_r, 0);
      check_int("fresh_press_level3", int'(bus.key_level[3]), 1);
      bus.key_in[3] = 1'b1;
      step(80);

      // long hold on key 0 (auto-repeat when built in)
      snap_p = act_press[0]; snap_ep = exp_press[0];
      bus.key_in[0] = 1'b1;
      step(300);
      bus.key_in[0] = 1'b0;
      step(80);
      check_int("hold30_press0_vs_model", act_press[0] - snap_p, exp_press[0] - snap_ep);
`ifndef KEY_DEBOUNCE_AUTOREPEAT_EN
      check_int("hold30_single_press0", act_press[0] - snap_p, 1);
`endif

      // random activity on every key
      for (int k = 0; k < N; k++) remain[k] = $urandom_range(3, 150);
      for (int c = 0; c < 2500; c++) begin
         for (int k = 0; k < N; k++) begin
            if (remain[k] == 0) begin
               bus.key_in[k] = ~bus.key_in[k];
               remain[k] = $urandom_range(3, 150);
            end else begin
               remain[k]--;
            end
         end
         step(1);
      end
      bus.key_in = INV;
      step(100);

      for (int k = 0; k < N; k++) begin
         check_int($sformatf("total_press%0d", k), act_press[k], exp_press[k]);
         check_int($sformatf("total_release%0d", k), act_rel[k], exp_rel[k]);
         check_int($sformatf("total_long%0d", k), act_long[k], exp_long[k]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
